// File: rtl/reg_read_forward_pkg.sv
// -----------------------------------------------------------------------------
// reg_read_forward_pkg
// Shared definitions for the operand-read / forwarding unit:
//   REG_ADDR_BUS, DATA_BUS : default register address and data widths
//   ZERO_REG               : index of the hardwired-zero register
//   fwd_src_e              : operand source selected by each read port
// -----------------------------------------------------------------------------
package reg_read_forward_pkg;

    localparam int REG_ADDR_BUS = 5;
    localparam int DATA_BUS     = 32;
    localparam int ZERO_REG     = 0;

    // Sources in descending forwarding priority.
    typedef enum logic [2:0] {
        FWD_SRC_EX  = 3'd0,
        FWD_SRC_MEM = 3'd1,
        FWD_SRC_LD  = 3'd2,
        FWD_SRC_WB  = 3'd3,
        FWD_SRC_RF  = 3'd4
    } fwd_src_e;

endpackage

// File: rtl/reg_read_forward_if.sv
// -----------------------------------------------------------------------------
// reg_read_forward_if
// Bundles every pipeline-facing signal of reg_read_forward.
//   master : the pipeline side (drives reads, results, load events; sees
//            forwarded operands, stall requests, status and counter)
//   slave  : the forwarding unit
// Read-port vectors are flattened; port i occupies [i*W +: W].
// -----------------------------------------------------------------------------
interface reg_read_forward_if
    import reg_read_forward_pkg::*;
#(
    parameter int READ_PORTS = 2,
    parameter int DATA_WIDTH = DATA_BUS,
    parameter int ADDR_WIDTH = REG_ADDR_BUS
);
    // Read ports
    logic [READ_PORTS-1:0]            read_en;
    logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr;
    logic [READ_PORTS*DATA_WIDTH-1:0] data_from_reg;
    // EX-stage result
    logic                             ex_write_en;
    logic [ADDR_WIDTH-1:0]            ex_write_addr;
    logic [DATA_WIDTH-1:0]            ex_data;
    logic                             ex_load_flag;
    // MEM-stage result
    logic                             mem_write_en;
    logic [ADDR_WIDTH-1:0]            mem_write_addr;
    logic [DATA_WIDTH-1:0]            mem_data;
    logic                             mem_load_flag;
    // Load issue / completion
    logic                             ld_issue_valid;
    logic [ADDR_WIDTH-1:0]            ld_issue_addr;
    logic                             ld_done_valid;
    logic [ADDR_WIDTH-1:0]            ld_done_addr;
    logic [DATA_WIDTH-1:0]            ld_done_data;
    // Non-load write-back
    logic                             wb_write_en;
    logic [ADDR_WIDTH-1:0]            wb_write_addr;
    logic [DATA_WIDTH-1:0]            wb_data;
    // Results
    logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic [READ_PORTS-1:0]            load_related;
    logic                             ld_full;
    logic                             err_overflow;
    logic                             err_unexpected;
    logic [31:0]                      stall_cycles;

    modport master (
        output read_en, read_addr, data_from_reg,
        output ex_write_en, ex_write_addr, ex_data, ex_load_flag,
        output mem_write_en, mem_write_addr, mem_data, mem_load_flag,
        output ld_issue_valid, ld_issue_addr,
        output ld_done_valid, ld_done_addr, ld_done_data,
        output wb_write_en, wb_write_addr, wb_data,
        input  read_data, load_related, ld_full,
        input  err_overflow, err_unexpected, stall_cycles
    );

    modport slave (
        input  read_en, read_addr, data_from_reg,
        input  ex_write_en, ex_write_addr, ex_data, ex_load_flag,
        input  mem_write_en, mem_write_addr, mem_data, mem_load_flag,
        input  ld_issue_valid, ld_issue_addr,
        input  ld_done_valid, ld_done_addr, ld_done_data,
        input  wb_write_en, wb_write_addr, wb_data,
        output read_data, load_related, ld_full,
        output err_overflow, err_unexpected, stall_cycles
    );

endinterface

// File: rtl/reg_read_forward_port.sv
// -----------------------------------------------------------------------------
// reg_read_forward_port
// Single read port: operand source selection and load-use hazard detection.
// Purely combinational.
//   read_en/read_addr/data_from_reg : the port's request and regfile data
//   ex_* / mem_* / ld_done_* / wb_* : forwarding sources
//   pending                         : scoreboard bit for read_addr
//   read_data, load_related         : forwarded operand and stall request
// Optional feature macro: REG_READ_FWD_WB_BYPASS_EN (WB joins forwarding).
// -----------------------------------------------------------------------------
module reg_read_forward_port
    import reg_read_forward_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS,
    parameter int ADDR_WIDTH = REG_ADDR_BUS
) (
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] data_from_reg,
    input  logic                  ex_write_en,
    input  logic [ADDR_WIDTH-1:0] ex_write_addr,
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic                  ex_load_flag,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_write_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_load_flag,
    input  logic                  ld_done_valid,
    input  logic [ADDR_WIDTH-1:0] ld_done_addr,
    input  logic [DATA_WIDTH-1:0] ld_done_data,
    input  logic                  wb_write_en,
    input  logic [ADDR_WIDTH-1:0] wb_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  pending,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  load_related
);

    logic     active;
    logic     ex_hit;
    logic     mem_hit;
    logic     ld_hit;
    fwd_src_e src;

    assign active  = read_en && (read_addr != ADDR_WIDTH'(ZERO_REG));
    assign ex_hit  = ex_write_en   && (ex_write_addr  == read_addr);
    assign mem_hit = mem_write_en  && (mem_write_addr == read_addr);
    assign ld_hit  = ld_done_valid && (ld_done_addr   == read_addr);

`ifdef REG_READ_FWD_WB_BYPASS_EN
    logic wb_hit;
    assign wb_hit = wb_write_en && (wb_write_addr == read_addr);
`else
    // Regfile is write-before-read in this build, so WB is never consulted.
    logic unused_wb;
    assign unused_wb = ^{wb_write_en, wb_write_addr, wb_data};
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        src = FWD_SRC_RF;
        if (ex_hit)       src = FWD_SRC_EX;
        else if (mem_hit) src = FWD_SRC_MEM;
        else if (ld_hit)  src = FWD_SRC_LD;
`ifdef REG_READ_FWD_WB_BYPASS_EN
        else if (wb_hit)  src = FWD_SRC_WB;
`endif
    end

    always_comb begin
        read_data = '0;
        if (active) begin
            case (src)
                FWD_SRC_EX:  read_data = ex_data;
                FWD_SRC_MEM: read_data = mem_data;
                FWD_SRC_LD:  read_data = ld_done_data;
`ifdef REG_READ_FWD_WB_BYPASS_EN
                FWD_SRC_WB:  read_data = wb_data;
`endif
                default:     read_data = data_from_reg;
            endcase
        end
    end

    // A same-cycle completion satisfies an outstanding load, so the pending
    // bit only stalls when no matching ld_done is present.
    assign load_related = active &&
                          ((ex_load_flag && ex_hit) ||
                           (mem_load_flag && mem_hit) ||
                           (pending && !ld_hit));

endmodule

// File: rtl/reg_read_forward.sv
// -----------------------------------------------------------------------------
// reg_read_forward
// ID-stage operand read and forwarding unit with a load scoreboard.
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : reg_read_forward_if.slave carrying read ports, EX/MEM/WB results,
//          load issue/done events, forwarded operands, per-port stall
//          requests, ld_full, sticky error flags and the stall counter.
// One reg_read_forward_port per read port; the scoreboard (pending bits +
// outstanding count) and the stall counter live here.
// Optional feature macro: REG_READ_FWD_WB_BYPASS_EN (WB joins forwarding).
// -----------------------------------------------------------------------------
module reg_read_forward
    import reg_read_forward_pkg::*;
#(
    parameter int READ_PORTS = 2,
    parameter int DATA_WIDTH = DATA_BUS,
    parameter int ADDR_WIDTH = REG_ADDR_BUS,
    parameter int SB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_read_forward_if.slave     bus
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam int CNT_W    = $clog2(SB_DEPTH + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_overflow_q, err_overflow_d;
    logic                err_unexpected_q, err_unexpected_d;
    logic [31:0]         stall_q, stall_d;

    logic [READ_PORTS-1:0][DATA_WIDTH-1:0] port_data;
    logic [READ_PORTS-1:0]                 port_stall;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
        reg_read_forward_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_port (
            .read_en        (bus.read_en[i]),
            .read_addr      (bus.read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .data_from_reg  (bus.data_from_reg[i*DATA_WIDTH +: DATA_WIDTH]),
            .ex_write_en    (bus.ex_write_en),
            .ex_write_addr  (bus.ex_write_addr),
            .ex_data        (bus.ex_data),
            .ex_load_flag   (bus.ex_load_flag),
            .mem_write_en   (bus.mem_write_en),
            .mem_write_addr (bus.mem_write_addr),
            .mem_data       (bus.mem_data),
            .mem_load_flag  (bus.mem_load_flag),
            .ld_done_valid  (bus.ld_done_valid),
            .ld_done_addr   (bus.ld_done_addr),
            .ld_done_data   (bus.ld_done_data),
            .wb_write_en    (bus.wb_write_en),
            .wb_write_addr  (bus.wb_write_addr),
            .wb_data        (bus.wb_data),
            .pending        (pending_q[bus.read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]),
            .read_data      (port_data[i]),
            .load_related   (port_stall[i])
        );
    end

    assign bus.read_data    = port_data;
    assign bus.load_related = port_stall;

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------
    logic full;
    logic issue_nz;
    logic issue_ok;
    logic done_hit;

    assign full     = (count_q == CNT_W'(SB_DEPTH));
    assign issue_nz = bus.ld_issue_valid && (bus.ld_issue_addr != ADDR_WIDTH'(ZERO_REG));
    assign issue_ok = issue_nz && !full;
    assign done_hit = bus.ld_done_valid && pending_q[bus.ld_done_addr];

    always_comb begin
        pending_d = pending_q;
        // Clear before set: a same-address issue and done leaves the bit set,
        // since the younger load now owns the register.
        if (done_hit) pending_d[bus.ld_done_addr]  = 1'b0;
        if (issue_ok) pending_d[bus.ld_issue_addr] = 1'b1;

        case ({issue_ok, done_hit})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        err_overflow_d   = err_overflow_q   || (issue_nz && full);
        err_unexpected_d = err_unexpected_q ||
                           (bus.ld_done_valid && !pending_q[bus.ld_done_addr]);

        stall_d = stall_q;
        if ((|port_stall) && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            pending_q        <= '0;
            count_q          <= '0;
            err_overflow_q   <= 1'b0;
            err_unexpected_q <= 1'b0;
            stall_q          <= '0;
        end else begin
            pending_q        <= pending_d;
            count_q          <= count_d;
            err_overflow_q   <= err_overflow_d;
            err_unexpected_q <= err_unexpected_d;
            stall_q          <= stall_d;
        end
    end

    assign bus.ld_full        = full;
    assign bus.err_overflow   = err_overflow_q;
    assign bus.err_unexpected = err_unexpected_q;
    assign bus.stall_cycles   = stall_q;

endmodule

// File: tb/tb_reg_read_forward.sv
// -----------------------------------------------------------------------------
// tb_reg_read_forward
// Self-checking bench for reg_read_forward (2 read ports, 32-bit data,
// 5-bit addresses, 4-entry scoreboard). Expected values are queued as each
// cycle's stimulus is applied and compared against the sampled outputs.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_reg_read_forward;
    import reg_read_forward_pkg::*;

    localparam int RP  = 2;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int SBD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_read_forward_if #(.READ_PORTS(RP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_read_forward #(
        .READ_PORTS (RP),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SB_DEPTH   (SBD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   exp_stall = 0;

    task automatic push(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.read_en        = '0;
        bus.read_addr      = '0;
        bus.data_from_reg  = '0;
        bus.ex_write_en    = 1'b0;
        bus.ex_write_addr  = '0;
        bus.ex_data        = '0;
        bus.ex_load_flag   = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_write_addr = '0;
        bus.mem_data       = '0;
        bus.mem_load_flag  = 1'b0;
        bus.ld_issue_valid = 1'b0;
        bus.ld_issue_addr  = '0;
        bus.ld_done_valid  = 1'b0;
        bus.ld_done_addr   = '0;
        bus.ld_done_data   = '0;
        bus.wb_write_en    = 1'b0;
        bus.wb_write_addr  = '0;
        bus.wb_data        = '0;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] o;
        logic [31:0] obs[$];
        rst = 1'b1;
        idle_inputs();
        bus.read_en   = 2'b11;
        bus.read_addr = {5'd5, 5'd5};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        push("rst_ld_full", 0); push("rst_err_overflow", 0);
        push("rst_err_unexpected", 0); push("rst_stall_cycles", 0);
        push("rst_load_related", 0);
        #1;
        obs.push_back(32'(bus.ld_full));      obs.push_back(32'(bus.err_overflow));
        obs.push_back(32'(bus.err_unexpected)); obs.push_back(bus.stall_cycles);
        obs.push_back(32'(bus.load_related));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_errors++;
                $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_priority();
        exp_t        e;
        logic [31:0] o;
        logic [31:0] obs[$];
        @(negedge clk);
        idle_inputs();
        bus.read_en              = 2'b01;
        bus.read_addr            = {5'd3, 5'd3};
        bus.data_from_reg        = {32'h55, 32'h99};
        bus.ex_write_en          = 1'b1; bus.ex_write_addr  = 5'd3; bus.ex_data  = 32'h11;
        bus.mem_write_en         = 1'b1; bus.mem_write_addr = 5'd3; bus.mem_data = 32'h22;
        bus.wb_write_en          = 1'b1; bus.wb_write_addr  = 5'd3; bus.wb_data  = 32'h44;
        push("prio_ex_data", 32'h11); push("prio_ex_no_stall", 0); push("disabled_port_zero", 0);
        #1;
        obs.push_back(bus.read_data[31:0]); obs.push_back(32'(bus.load_related[0]));
        obs.push_back(bus.read_data[63:32]);

        @(negedge clk);
        bus.ex_write_en = 1'b0;
        push("prio_mem_data", 32'h22);
        #1 obs.push_back(bus.read_data[31:0]);

        @(negedge clk);
        bus.mem_write_en = 1'b0;
`ifdef REG_READ_FWD_WB_BYPASS_EN
        push("prio_wb_data", 32'h44);
`else
        push("prio_wb_ignored", 32'h99);
`endif
        #1 obs.push_back(bus.read_data[31:0]);

        @(negedge clk);
        bus.wb_write_en = 1'b0;
        push("prio_regfile_data", 32'h99);
        #1 obs.push_back(bus.read_data[31:0]);

        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_errors++;
                $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t        e;
        logic [31:0] o;
        logic [31:0] obs[$];
        // Issue r5 with no readers.
        @(negedge clk);
        idle_inputs();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = 5'd5;
        // Two idle cycles with port1 reading r5.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            idle_inputs();
            bus.read_en   = 2'b10;
            bus.read_addr = {5'd5, 5'd0};
            push($sformatf("lu_stall_cycle%0d", c), 1);
            exp_stall++;
            #1 obs.push_back(32'(bus.load_related[1]));
        end
        // Completion forwards in the same cycle.
        @(negedge clk);
        bus.ld_done_valid = 1'b1; bus.ld_done_addr = 5'd5; bus.ld_done_data = 32'hAB;
        push("lu_stall_count", 32'(exp_stall)); push("lu_done_fwd", 32'hAB);
        push("lu_done_no_stall", 0);
        #1;
        obs.push_back(bus.stall_cycles); obs.push_back(bus.read_data[63:32]);
        obs.push_back(32'(bus.load_related[1]));
        // Afterwards the regfile supplies the value and the hazard is gone.
        @(negedge clk);
        idle_inputs();
        bus.read_en       = 2'b10;
        bus.read_addr     = {5'd5, 5'd0};
        bus.data_from_reg = {32'hAB, 32'h0};
        push("lu_after_rf_data", 32'hAB); push("lu_after_no_stall", 0);
        #1 obs.push_back(bus.read_data[63:32]); obs.push_back(32'(bus.load_related[1]));
        // EX and MEM load-flag hazards in one cycle (counts a single stall).
        @(negedge clk);
        idle_inputs();
        bus.read_en      = 2'b11;
        bus.read_addr    = {5'd10, 5'd6};
        bus.ex_write_en  = 1'b1; bus.ex_write_addr  = 5'd6;  bus.ex_data  = 32'h66;
        bus.ex_load_flag = 1'b1;
        bus.mem_write_en = 1'b1; bus.mem_write_addr = 5'd10; bus.mem_data = 32'h10;
        bus.mem_load_flag = 1'b1;
        push("ex_load_data", 32'h66); push("ex_load_stall", 1);
        push("mem_load_data", 32'h10); push("mem_load_stall", 1);
        exp_stall++;
        #1;
        obs.push_back(bus.read_data[31:0]);  obs.push_back(32'(bus.load_related[0]));
        obs.push_back(bus.read_data[63:32]); obs.push_back(32'(bus.load_related[1]));
        @(negedge clk);
        idle_inputs();
        push("lu_stall_total", 32'(exp_stall));
        #1 obs.push_back(bus.stall_cycles);

        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_errors++;
                $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_same_addr();
        exp_t        e;
        logic [31:0] o;
        logic [31:0] obs[$];
        @(negedge clk);
        idle_inputs();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = 5'd7;
        // r7 pending: issue and done on r7 together.
        @(negedge clk);
        bus.ld_done_valid = 1'b1; bus.ld_done_addr = 5'd7; bus.ld_done_data = 32'h77;
        bus.read_en = 2'b01; bus.read_addr = {5'd0, 5'd7};
        push("same_fwd_data", 32'h77); push("same_no_stall", 0);
        #1 obs.push_back(bus.read_data[31:0]); obs.push_back(32'(bus.load_related[0]));
        // r7 must still be pending; also issue r1.
        @(negedge clk);
        idle_inputs();
        bus.read_en = 2'b01; bus.read_addr = {5'd0, 5'd7};
        bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = 5'd1;
        push("same_still_pending", 1);
        exp_stall++;
        #1 obs.push_back(32'(bus.load_related[0]));
        @(negedge clk);
        idle_inputs();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = 5'd2;
        @(negedge clk);
        bus.ld_issue_addr = 5'd4;
        push("three_not_full", 0);
        #1 obs.push_back(32'(bus.ld_full));
        @(negedge clk);
        idle_inputs();
        push("four_full", 1);
        #1 obs.push_back(32'(bus.ld_full));

        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_errors++;
                $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_overflow();
        exp_t        e;
        logic [31:0] o;
        logic [31:0] obs[$];
        // Scoreboard holds r7, r1, r2, r4; a fifth issue must be dropped.
        @(negedge clk);
        idle_inputs();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_addr = 5'd8;
        push("ovf_before_flag", 0);
        #1 obs.push_back(32'(bus.err_overflow));
        @(negedge clk);
        idle_inputs();
        bus.read_en = 2'b01; bus.read_addr = {5'd0, 5'd8};
        push("ovf_flag_set", 1); push("ovf_still_full", 1); push("ovf_issue_dropped", 0);
        #1;
        obs.push_back(32'(bus.err_overflow)); obs.push_back(32'(bus.ld_full));
        obs.push_back(32'(bus.load_related[0]));
        @(negedge clk);
        idle_inputs();
        bus.ld_done_valid = 1'b1; bus.ld_done_addr = 5'd7; bus.ld_done_data = 32'h70;
        bus.read_en = 2'b01; bus.read_addr = {5'd0, 5'd7};
        push("ovf_done_fwd", 32'h70);
        #1 obs.push_back(bus.read_data[31:0]);
        @(negedge clk);
        idle_inputs();
        push("ovf_drained_not_full", 0); push("ovf_flag_sticky", 1);
        push("ovf_no_unexpected", 0);
        #1;
        obs.push_back(32'(bus.ld_full)); obs.push_back(32'(bus.err_overflow));
        obs.push_back(32'(bus.err_unexpected));

        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_errors++;
                $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_unexpected();
        exp_t        e;
        logic [31:0] o;
        logic [31:0] obs[$];
        @(negedge clk);
        idle_inputs();
        bus.ld_done_valid = 1'b1; bus.ld_done_addr = 5'd9; bus.ld_done_data = 32'h5;
        bus.ex_write_en   = 1'b1; bus.ex_write_addr = 5'd0; bus.ex_data = 32'hDEAD;
        bus.ex_load_flag  = 1'b1;
        bus.read_en       = 2'b11;
        bus.read_addr     = {5'd0, 5'd9};
        bus.data_from_reg = {32'h1234, 32'h0};
        push("unexp_fwd_data", 32'h5); push("unexp_no_stall", 0);
        push("r0_read_zero", 0); push("r0_no_stall", 0);
        #1;
        obs.push_back(bus.read_data[31:0]);  obs.push_back(32'(bus.load_related[0]));
        obs.push_back(bus.read_data[63:32]); obs.push_back(32'(bus.load_related[1]));
        @(negedge clk);
        idle_inputs();
        bus.read_en = 2'b01; bus.read_addr = {5'd0, 5'd9};
        push("unexp_flag_set", 1); push("unexp_r9_not_pending", 0);
        push("unexp_count_kept", 0); push("stall_total", 32'(exp_stall));
        #1;
        obs.push_back(32'(bus.err_unexpected)); obs.push_back(32'(bus.load_related[0]));
        obs.push_back(32'(bus.ld_full));        obs.push_back(bus.stall_cycles);

        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_errors++;
                $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_reset_pending();
        exp_t        e;
        logic [31:0] o;
        logic [31:0] obs[$];
        // r1, r2, r4 outstanding.
        @(negedge clk);
        idle_inputs();
        bus.read_en = 2'b01; bus.read_addr = {5'd0, 5'd1};
        push("rp_before_stall", 1);
        #1 obs.push_back(32'(bus.load_related[0]));
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.read_en = 2'b11; bus.read_addr = {5'd4, 5'd2};
        push("rp_no_stall", 0); push("rp_ld_full", 0); push("rp_err_overflow", 0);
        push("rp_err_unexpected", 0); push("rp_stall_cycles", 0);
        #1;
        obs.push_back(32'(bus.load_related)); obs.push_back(32'(bus.ld_full));
        obs.push_back(32'(bus.err_overflow)); obs.push_back(32'(bus.err_unexpected));
        obs.push_back(bus.stall_cycles);
        @(negedge clk);
        idle_inputs();
        bus.ld_done_valid = 1'b1; bus.ld_done_addr = 5'd1; bus.ld_done_data = 32'h12;
        bus.read_en = 2'b01; bus.read_addr = {5'd0, 5'd1};
        push("rp_done_fwd", 32'h12);
        #1 obs.push_back(bus.read_data[31:0]);
        @(negedge clk);
        idle_inputs();
        push("rp_done_unexpected", 1); push("rp_stall_still_zero", 0);
        #1 obs.push_back(32'(bus.err_unexpected)); obs.push_back(bus.stall_cycles);

        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : 'x;
            n_checks++;
            if (o !== e.val) begin
                n_errors++;
                $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_load_use();
        test_same_addr();
        test_overflow();
        test_unexpected();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_read_forward.md
# reg_read_forward

Parametrised operand-read and forwarding unit for the ID stage. It serves `READ_PORTS` register read ports and forwards results from EX, MEM and write-back. A scoreboard tracks outstanding variable-latency loads so that load-use hazards stay correct when data-cache responses arrive out of the fixed pipeline timing. It sits between the regfile and the ID stage and drives the pipeline stall controller.

## Interface
Parameters:
- `READ_PORTS`, 2: number of read ports (1–4).
- `DATA_WIDTH`, 32: register data width.
- `ADDR_WIDTH`, 5: register address width; register 0 is hardwired zero.
- `SB_DEPTH`, 4: maximum outstanding loads (power of two, 2–16).

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `read_en` in READ_PORTS: per-port read enable.
- `read_addr` in READ_PORTS×ADDR_WIDTH: flattened; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `data_from_reg` in READ_PORTS×DATA_WIDTH: regfile read data, flattened the same way.
- `ex_write_en`, `ex_write_addr`, `ex_data`, `ex_load_flag` in 1/ADDR_WIDTH/DATA_WIDTH/1: EX-stage result.
- `mem_write_en`, `mem_write_addr`, `mem_data`, `mem_load_flag` in 1/ADDR_WIDTH/DATA_WIDTH/1: MEM-stage result.
- `ld_issue_valid`, `ld_issue_addr` in 1/ADDR_WIDTH: a load leaves MEM and becomes outstanding.
- `ld_done_valid`, `ld_done_addr`, `ld_done_data` in 1/ADDR_WIDTH/DATA_WIDTH: load response, which is also the regfile write.
- `wb_write_en`, `wb_write_addr`, `wb_data` in 1/ADDR_WIDTH/DATA_WIDTH: non-load write-back.
- `read_data` out READ_PORTS×DATA_WIDTH: forwarded operands.
- `load_related` out READ_PORTS: per-port stall request.
- `ld_full` out 1: the scoreboard holds SB_DEPTH loads; MEM must not issue.
- `err_overflow`, `err_unexpected` out 1: sticky error flags.
- `stall_cycles` out 32: performance counter.

## Operation
- Operand select, per port i, combinational. If `read_en[i]`=0 or `read_addr`=0, the port outputs 0. Otherwise the first match wins, in this order:
  - EX write
  - MEM write
  - `ld_done`
  - WB (see Configuration)
  - `data_from_reg`
- A match requires the source's enable bit and an equal address.
- `load_related[i]` is asserted when the port is enabled, the address is nonzero, and any of these holds:
  - `ex_load_flag` with an EX address match;
  - `mem_load_flag` with a MEM address match;
  - `pending[addr]` is set and there is no same-cycle `ld_done` match.
- Scoreboard state: `pending[1..2^ADDR_WIDTH-1]` bits and `count` (0..SB_DEPTH).
  - Valid issue with nonzero address and `count`<SB_DEPTH: set `pending`, `count`+1.
  - Valid done on a pending address: clear `pending`, `count`−1.
  - Issue and done on the same address in the same cycle: `pending` stays set and `count` is unchanged (the younger load owns the register).
  - Issue and done on different addresses in the same cycle: both apply and `count` is unchanged.
  - Issue to register 0: ignored.
  - Issue while `count`=SB_DEPTH: ignored and `err_overflow` set.
  - Done on a non-pending address: scoreboard unchanged and `err_unexpected` set. Data is still forwarded.
- `ld_full` = (`count`==SB_DEPTH), decoded from state.
- `stall_cycles` increments on every cycle where any `load_related` bit is set, and saturates at 0xFFFFFFFF.

## Timing
- Reset: `pending`, `count`, both error flags and `stall_cycles` clear to 0. `read_data` and `load_related` are combinational and respond to inputs immediately.
- Operand path and `load_related` have zero latency.
- Scoreboard updates are visible the cycle after issue or done. During the issue cycle the load is still covered by `mem_load_flag`.
- A done forwards in the same cycle; from the next cycle the regfile supplies the value.
- Reset asserted with loads outstanding drops them. A done arriving after reset sets `err_unexpected`.

## Configuration
- `REG_READ_FWD_WB_BYPASS_EN`:
  - Defined: the WB write participates in forwarding at the priority given above.
  - Undefined: the WB source is not used and the regfile is assumed write-before-read. The `wb_*` ports remain but are unused.

## Structure
- Shared package/header (`bus.v` style):
  - `REG_ADDR_BUS` and `DATA_BUS` widths.
  - Zero-register constant.
  - Source-select encoding: `FWD_SRC_EX`, `FWD_SRC_MEM`, `FWD_SRC_LD`, `FWD_SRC_WB`, `FWD_SRC_RF`.
- Sub-module `RegFwdPort`: single-port select plus hazard logic, generate-instantiated READ_PORTS times. The scoreboard and counter live in the top.

## Test plan
- EX write r3=0x11 and MEM write r3=0x22 in the same cycle, port0 reads r3 → `read_data0`=0x11, no stall.
- Issue a load to r5, then idle two cycles while port1 reads r5 → `load_related[1]`=1 each cycle and `stall_cycles`=2. Then done r5 with data 0xAB → same-cycle `read_data1`=0xAB and `load_related[1]`=0.
- Issue to r7 and done to r7 in the same cycle with r7 already pending → r7 stays pending and `count` is unchanged.
- Fill four issues (SB_DEPTH=4) → `ld_full`=1. A fifth issue → ignored, `err_overflow`=1, `count`=4.
- Done to non-pending r9 with data 0x5 → `err_unexpected`=1 and the forward still yields 0x5. Port reads r0 while EX writes r0 → output 0, no stall.
- Assert reset with three loads pending → next cycle `count`=0, no stalls, flags clear.
